// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a shared Montgomery multiplier core.
// Schedules operand selection and result capture only; all arithmetic lives in the core.
module mont_modexp_ctrl #(
  parameter int unsigned K_BITS   = 256,
  parameter int unsigned EXP_BITS = 256,
  localparam int unsigned LenW    = $clog2(EXP_BITS) + 1,
  localparam int unsigned IdxW    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [K_BITS-1:0] i_Base_M,
  input  logic [K_BITS-1:0] i_R_mod_m,
  input  logic [K_BITS-1:0] i_m,
  input  logic [EXP_BITS-1:0] i_Exp,
  input  logic [LenW-1:0]   i_Exp_Len,
  output logic              o_Mul_Start,
  output logic [K_BITS-1:0] o_Mul_A,
  output logic [K_BITS-1:0] o_Mul_B,
  output logic [K_BITS-1:0] o_Mul_m,
  input  logic [K_BITS-1:0] i_Mul_P,
  input  logic              i_Mul_Done,
  output logic [K_BITS-1:0] o_Result,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Err
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StDispatch, StIssue, StRelease, StDone
  } state_e;

  typedef enum logic [1:0] {OpSqr, OpMul, OpConv} op_e;

  localparam logic [K_BITS-1:0] One = {{(K_BITS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [K_BITS-1:0]   base_q, base_d;
  logic [K_BITS-1:0]   m_q, m_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [K_BITS-1:0]   x_q, x_d;
  logic                mul_start_q, mul_start_d;
  logic [K_BITS-1:0]   mul_a_q, mul_a_d;
  logic [K_BITS-1:0]   mul_b_q, mul_b_d;
  logic [K_BITS-1:0]   mul_m_q, mul_m_d;
  logic [K_BITS-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    m_d         = m_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    x_d         = x_q;
    mul_start_d = mul_start_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_m_d     = mul_m_q;
    result_d    = result_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (i_Start) state_d = StLoad;
      end
      StLoad: begin
        base_d   = i_Base_M;
        m_d      = i_m;
        exp_d    = i_Exp;
        x_d      = i_R_mod_m;
        idx_d    = IdxW'(i_Exp_Len - LenW'(1));
        result_d = '0;
        if (!i_m[0] || (i_Exp_Len > LenW'(EXP_BITS))) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          err_d   = 1'b0;
          op_d    = (i_Exp_Len != '0) ? OpSqr : OpConv;
          state_d = StDispatch;
        end
      end
      StDispatch: begin
        mul_a_d = x_q;
        mul_m_d = m_q;
        unique case (op_q)
          OpSqr:   mul_b_d = x_q;
          OpMul:   mul_b_d = base_q;
          default: mul_b_d = One;
        endcase
        mul_start_d = 1'b1;
        state_d     = StIssue;
      end
      StIssue: begin
        if (i_Mul_Done) begin
          x_d         = i_Mul_P;
          mul_start_d = 1'b0;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        // Hold off the next op until the core has lowered done.
        if (!i_Mul_Done) begin
          state_d = StDispatch;
          unique case (op_q)
            OpSqr: begin
              if (exp_q[idx_q]) begin
                op_d = OpMul;
              end else if (idx_q == '0) begin
                op_d = OpConv;
              end else begin
                idx_d = idx_q - IdxW'(1);
                op_d  = OpSqr;
              end
            end
            OpMul: begin
              if (idx_q == '0) begin
                op_d = OpConv;
              end else begin
                idx_d = idx_q - IdxW'(1);
                op_d  = OpSqr;
              end
            end
            default: begin
              result_d = x_q;
              state_d  = StDone;
            end
          endcase
        end
      end
      StDone: begin
        if (!i_Start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      op_q        <= OpSqr;
      base_q      <= '0;
      m_q         <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_m_q     <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      m_q         <= m_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_m_q     <= mul_m_d;
      result_q    <= result_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_Mul_Start = mul_start_q;
  assign o_Mul_A     = mul_a_q;
  assign o_Mul_B     = mul_b_q;
  assign o_Mul_m     = mul_m_q;
  assign o_Result    = result_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl: behavioural Montgomery core with random latency, vector table,
// hand-written reset/hold sequences and randomized requests against a plain powmod model.
module tb_mont_modexp_ctrl;
  localparam int unsigned KB = 8;
  localparam int unsigned EB = 8;
  localparam int unsigned LW = $clog2(EB) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KB-1:0] base_m, rmod, m;
  logic [EB-1:0] exp_v;
  logic [LW-1:0] len;
  logic          mul_start, mul_done;
  logic [KB-1:0] mul_a, mul_b, mul_m, mul_p;
  logic [KB-1:0] result;
  logic          busy, done, err;

  always #5 clk = ~clk;

  mont_modexp_ctrl #(.K_BITS(KB), .EXP_BITS(EB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .i_Base_M(base_m), .i_R_mod_m(rmod), .i_m(m), .i_Exp(exp_v), .i_Exp_Len(len),
    .o_Mul_Start(mul_start), .o_Mul_A(mul_a), .o_Mul_B(mul_b), .o_Mul_m(mul_m),
    .i_Mul_P(mul_p), .i_Mul_Done(mul_done),
    .o_Result(result), .o_Busy(busy), .o_Done(done), .o_Err(err)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // a*b*2^-KB mod mm via bitwise REDC, fully reduced.
  function automatic logic [KB-1:0] mont(input logic [KB-1:0] a, b, mm);
    longint t;
    t = longint'(a) * longint'(b);
    for (int i = 0; i < KB; i++) begin
      if ((t % 2) == 1) t = t + longint'(mm);
      t = t / 2;
    end
    if (t >= longint'(mm)) t = t - longint'(mm);
    return KB'(t);
  endfunction

  function automatic int powmod(input int b, input int e, input int mm);
    longint r, bb;
    r  = 1 % mm;
    bb = b % mm;
    for (int i = 0; i < 31; i++) begin
      if (((e >> i) & 1) == 1) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return int'(r);
  endfunction

  // Multiplier core model: captures operands on start, answers after 1..4 cycles,
  // holds done until start drops, then releases it after 0..2 more cycles.
  int cst = 0, clat = 0, dhold = 0;
  logic [KB-1:0] ca, cb, cm;
  logic [KB-1:0] log_a[$], log_b[$], log_m[$];

  always @(posedge clk) begin
    if (rst) begin
      cst      <= 0;
      mul_done <= 1'b0;
      mul_p    <= '0;
    end else begin
      case (cst)
        0: if (mul_start) begin
          ca <= mul_a; cb <= mul_b; cm <= mul_m;
          log_a.push_back(mul_a); log_b.push_back(mul_b); log_m.push_back(mul_m);
          clat <= $urandom_range(0, 3);
          cst  <= 1;
        end
        1: if (clat == 0) begin
          mul_done <= 1'b1;
          mul_p    <= mont(ca, cb, cm);
          dhold    <= $urandom_range(0, 2);
          cst      <= 2;
        end else begin
          clat <= clat - 1;
        end
        default: if (!mul_start) begin
          if (dhold == 0) begin
            mul_done <= 1'b0;
            cst      <= 0;
          end else begin
            dhold <= dhold - 1;
          end
        end
      endcase
    end
  end

  // Handshake monitor: no start rise while done is high, operands stable under start.
  int viol = 0;
  logic prev_start = 1'b0;
  logic [KB-1:0] prev_a, prev_b, prev_m;
  always @(posedge clk) begin
    prev_start <= mul_start;
    prev_a <= mul_a; prev_b <= mul_b; prev_m <= mul_m;
    if (!rst) begin
      if (mul_start && !prev_start && mul_done) viol <= viol + 1;
      if (mul_start && prev_start && (mul_a != prev_a || mul_b != prev_b || mul_m != prev_m))
        viol <= viol + 1;
    end
  end

  task automatic clear_log();
    log_a.delete(); log_b.delete(); log_m.delete();
  endtask

  // Expected op order comes from the exponent bits; operand A chains through the core.
  task automatic check_ops(input string tag, input logic [KB-1:0] mm, rm, bm,
                           input int e, input int ln);
    int kinds[$];
    int nbad;
    logic [KB-1:0] x, eb;
    nbad = 0;
    for (int i = ln - 1; i >= 0; i--) begin
      kinds.push_back(0);
      if (((e >> i) & 1) == 1) kinds.push_back(1);
    end
    kinds.push_back(2);
    x = rm;
    for (int k = 0; k < kinds.size(); k++) begin
      eb = (kinds[k] == 0) ? x : (kinds[k] == 1) ? bm : KB'(1);
      if (k >= log_a.size()) nbad++;
      else if (log_a[k] != x || log_b[k] != eb || log_m[k] != mm) nbad++;
      x = mont(x, eb, mm);
    end
    check({tag, "_opseq"}, nbad, 0);
  endtask

  task automatic run_txn(input string tag, input logic [KB-1:0] mm, rm, bm,
                         input logic [EB-1:0] e, input logic [LW-1:0] ln,
                         input logic [KB-1:0] want_res, input logic want_err,
                         input int want_starts, input int hold);
    int cyc, first;
    logic busy1, stable;
    logic [KB-1:0] r0;
    cyc = 0; first = -1; busy1 = 1'b0; stable = 1'b1;
    @(negedge clk);
    clear_log();
    m = mm; rmod = rm; base_m = bm; exp_v = e; len = ln;
    start = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = busy;
      if (cyc == 2) begin
        // Inputs are don't-care once latched.
        m = KB'($urandom); rmod = KB'($urandom); base_m = KB'($urandom);
        exp_v = EB'($urandom); len = LW'($urandom);
      end
      if (mul_start && first < 0) first = cyc;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_load"}, busy1, 1);
    if (want_err) check({tag, "_err_latency"}, cyc, 2);
    else check({tag, "_first_start_cyc"}, first, 3);
    check({tag, "_result"}, result, want_res);
    check({tag, "_err"}, err, want_err);
    check({tag, "_starts"}, log_a.size(), want_starts);
    if (!want_err) check_ops(tag, mm, rm, bm, int'(e), int'(ln));
    check({tag, "_handshake_viol"}, viol, 0);
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!done || busy || result != r0) stable = 1'b0;
    end
    check({tag, "_done_hold_stable"}, stable, 1);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after_drop"}, done, 0);
    check({tag, "_result_persist"}, result, want_res);
  endtask

  typedef struct {
    logic [KB-1:0] m, rm, bm;
    logic [EB-1:0] e;
    logic [LW-1:0] ln;
    logic [KB-1:0] res;
    logic          err;
    int            starts;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rises;
    logic prev_neg;

    vecs[0] = '{8'd13, 8'd9, 8'd5, 8'h05, 4'd3, 8'd6, 1'b0, 6};
    vecs[1] = '{8'd13, 8'd9, 8'd1, 8'hFF, 4'd8, 8'd1, 1'b0, 17};
    vecs[2] = '{8'd13, 8'd9, 8'd5, 8'h05, 4'd0, 8'd1, 1'b0, 1};
    vecs[3] = '{8'd12, 8'd4, 8'd5, 8'h05, 4'd3, 8'd0, 1'b1, 0};
    vecs[4] = '{8'd13, 8'd9, 8'd5, 8'h05, 4'd9, 8'd0, 1'b1, 0};
    vecs[5] = '{8'd13, 8'd9, 8'd5, 8'h02, 4'd2, 8'd4, 1'b0, 4};
    vecs[6] = '{8'd1,  8'd0, 8'd0, 8'h03, 4'd2, 8'd0, 1'b0, 5};

    rst = 1'b1; start = 1'b0;
    m = '0; rmod = '0; base_m = '0; exp_v = '0; len = '0;
    repeat (3) @(negedge clk);
    check("rst_mul_start", mul_start, 0);
    check("rst_operands", {mul_a, mul_b, mul_m}, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].rm, vecs[i].bm, vecs[i].e,
              vecs[i].ln, vecs[i].res, vecs[i].err, vecs[i].starts, 1);

    // Reset during the third ISSUE, then a clean request must still complete.
    @(negedge clk);
    clear_log();
    m = vecs[0].m; rmod = vecs[0].rm; base_m = vecs[0].bm; exp_v = vecs[0].e; len = vecs[0].ln;
    start = 1'b1;
    rises = 0; prev_neg = 1'b0;
    for (int c = 0; c < 3000 && rises < 3; c++) begin
      @(negedge clk);
      if (mul_start && !prev_neg) rises++;
      prev_neg = mul_start;
    end
    check("midrst_reached_issue3", rises, 3);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("midrst_mul_start", mul_start, 0);
    check("midrst_operands", {mul_a, mul_b, mul_m}, 0);
    check("midrst_result", result, 0);
    check("midrst_busy_done_err", {busy, done, err}, 0);
    rst = 1'b0;
    run_txn("after_rst", vecs[0].m, vecs[0].rm, vecs[0].bm, vecs[0].e, vecs[0].ln,
            vecs[0].res, vecs[0].err, vecs[0].starts, 1);

    // Long hold in DONE, then drop and re-raise with a new request.
    run_txn("hold", vecs[0].m, vecs[0].rm, vecs[0].bm, vecs[0].e, vecs[0].ln,
            vecs[0].res, vecs[0].err, vecs[0].starts, 8);
    run_txn("reraise", 8'd13, 8'd9, 8'd5, 8'h02, 4'd2, 8'd4, 1'b0, 4, 1);

    for (int t = 0; t < 25; t++) begin
      int mm, b, bm, rm, e, ln, pe;
      mm = 2 * $urandom_range(0, 31) + 1;
      b  = $urandom_range(0, mm - 1);
      bm = (b * 256) % mm;
      rm = 256 % mm;
      e  = $urandom_range(0, 255);
      ln = $urandom_range(0, 8);
      pe = e & ((1 << ln) - 1);
      run_txn($sformatf("rnd%0d", t), KB'(mm), KB'(rm), KB'(bm), EB'(e), LW'(ln),
              KB'(powmod(b, pe, mm)), 1'b0, ln + $countones(pe) + 1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
